memory_bridge: RTL and testbench

//  Single-outstanding-request bridge between the multi-cycle controller's memory handshake
//  (memory_enable/memory_command in, memory_ready/memory_valid out) and a variable-latency
//  req/ack system bus (SRAM, ROM, MMIO). Sits directly below the controller's fetch and

---
 rtl/memory_bridge.sv | 185 ++++++++++++++++++
 tb/tb_memory_bridge.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_bridge.sv
// -----------------------------------------------------------------------------
// memory_bridge
//
// Single-outstanding-request bridge between the multi-cycle controller's
// memory handshake and a variable-latency req/ack system bus.
//
// One request is latched while the bridge is idle. It is then held on the bus
// until the bus acknowledges it or until the timeout expires. The result is
// returned to the core as a one-cycle memory_valid pulse, together with the
// read data or a bus error flag.
//
// Ports
//   clk            in   1   clock; all state changes on the rising edge
//   reset          in   1   synchronous, active-high
//   memory_enable  in   1   core request strobe; taken only while memory_ready=1
//   memory_command in   1   0=read, 1=write; sampled at acceptance
//   address        in   32  byte address; sampled at acceptance
//   write_data     in   32  lane-aligned store data; sampled at acceptance
//   byte_enable    in   4   active byte lanes; sampled at acceptance
//   memory_ready   out  1   bridge idle, can accept a request this cycle
//   memory_valid   out  1   one-cycle completion pulse
//   read_data      out  32  read result; held until the next completed read
//   bus_error      out  1   qualifies memory_valid: request timed out
//   bus_req        out  1   bus request, held until ack or timeout
//   bus_we         out  1   bus write enable
//   bus_addr       out  32  word-aligned bus address
//   bus_wdata      out  32  store data
//   bus_be         out  4   byte enables (all lanes on reads)
//   bus_ack        in   1   bus completion; honoured only while bus_req=1
//   bus_rdata      in   32  read data, valid in the bus_ack cycle
// -----------------------------------------------------------------------------
module memory_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TIMEOUT_WIDTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memory_enable,
  input  logic        memory_command,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic [3:0]  byte_enable,
  output logic        memory_ready,
  output logic        memory_valid,
  output logic [31:0] read_data,
  output logic        bus_error,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQUEST = 2'd1;
  localparam logic [1:0] ST_RESPOND = 2'd2;

  // Counter value of the last REQUEST cycle allowed before a timeout.
  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST =
    (TIMEOUT_CYCLES == 0) ? {TIMEOUT_WIDTH{1'b0}}
                          : TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  logic [1:0]               state_q,        state_d;
  logic [TIMEOUT_WIDTH-1:0] count_q,        count_d;
  logic                     memory_valid_q, memory_valid_d;
  logic                     bus_error_q,    bus_error_d;
  logic [31:0]              read_data_q,    read_data_d;
  logic                     bus_req_q,      bus_req_d;
  logic                     bus_we_q,       bus_we_d;
  logic [31:0]              bus_addr_q,     bus_addr_d;
  logic [31:0]              bus_wdata_q,    bus_wdata_d;
  logic [3:0]               bus_be_q,       bus_be_d;
  logic                     timeout_hit_s;

  // Byte-offset bits are intentionally dropped; lane choice is by byte_enable.
  logic addr_lsb_unused;
  assign addr_lsb_unused = ^address[1:0];

  assign timeout_hit_s = TIMEOUT_EN && (count_q == TIMEOUT_LAST);

  // Next-state and next-output logic for the request FSM.
  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    memory_valid_d = 1'b0;
    bus_error_d    = bus_error_q;
    read_data_d    = read_data_q;
    bus_req_d      = bus_req_q;
    bus_we_d       = bus_we_q;
    bus_addr_d     = bus_addr_q;
    bus_wdata_d    = bus_wdata_q;
    bus_be_d       = bus_be_q;

    case (state_q)
      ST_IDLE: begin
        if (memory_enable) begin
          state_d     = ST_REQUEST;
          count_d     = {TIMEOUT_WIDTH{1'b0}};
          bus_req_d   = 1'b1;
          bus_we_d    = memory_command;
          bus_addr_d  = {address[31:2], 2'b00};
          bus_wdata_d = write_data;
          // Reads always fetch the whole word.
          bus_be_d    = memory_command ? byte_enable : 4'b1111;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_REQUEST: begin
        // An ack in the final allowed cycle takes priority over the timeout.
        if (bus_ack) begin
          state_d        = ST_RESPOND;
          bus_req_d      = 1'b0;
          memory_valid_d = 1'b1;
          bus_error_d    = 1'b0;
          if (!bus_we_q) begin
            read_data_d = bus_rdata;
          end else begin
            read_data_d = read_data_q;
          end
        end else if (timeout_hit_s) begin
          state_d        = ST_RESPOND;
          bus_req_d      = 1'b0;
          memory_valid_d = 1'b1;
          bus_error_d    = 1'b1;
          read_data_d    = 32'h0000_0000;
        end else begin
          count_d = count_q + {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};
        end
      end

      ST_RESPOND: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d   = ST_IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      count_q        <= {TIMEOUT_WIDTH{1'b0}};
      memory_valid_q <= 1'b0;
      bus_error_q    <= 1'b0;
      read_data_q    <= 32'h0000_0000;
      bus_req_q      <= 1'b0;
      bus_we_q       <= 1'b0;
      bus_addr_q     <= 32'h0000_0000;
      bus_wdata_q    <= 32'h0000_0000;
      bus_be_q       <= 4'b0000;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      memory_valid_q <= memory_valid_d;
      bus_error_q    <= bus_error_d;
      read_data_q    <= read_data_d;
      bus_req_q      <= bus_req_d;
      bus_we_q       <= bus_we_d;
      bus_addr_q     <= bus_addr_d;
      bus_wdata_q    <= bus_wdata_d;
      bus_be_q       <= bus_be_d;
    end
  end

  // Ready is gated by reset so the core never sees it while reset is held.
  assign memory_ready = (state_q == ST_IDLE) && !reset;
  assign memory_valid = memory_valid_q;
  assign bus_error    = bus_error_q;
  assign read_data    = read_data_q;
  assign bus_req      = bus_req_q;
  assign bus_we       = bus_we_q;
  assign bus_addr     = bus_addr_q;
  assign bus_wdata    = bus_wdata_q;
  assign bus_be       = bus_be_q;

endmodule

// File: tb/tb_memory_bridge.sv
// -----------------------------------------------------------------------------
// tb_memory_bridge
//
// Directed self-checking bench for memory_bridge. The main instance uses the
// default timeout. A second instance with TIMEOUT_CYCLES=4 covers the timeout
// path. Completions of the main instance are checked against a scoreboard
// queue that is filled when each request is driven.
// -----------------------------------------------------------------------------
module tb_memory_bridge;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memory_enable = 1'b0;
  logic        to_enable = 1'b0;
  logic        memory_command = 1'b0;
  logic [31:0] address = 32'h0;
  logic [31:0] write_data = 32'h0;
  logic [3:0]  byte_enable = 4'h0;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'h0;

  logic        memory_ready, memory_valid, bus_error, bus_req, bus_we;
  logic [31:0] read_data, bus_addr, bus_wdata;
  logic [3:0]  bus_be;

  logic        to_ready, to_valid, to_err, to_bus_req, to_bus_we;
  logic [31:0] to_rdata, to_bus_addr, to_bus_wdata;
  logic [3:0]  to_bus_be;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   valid_cnt = 0;
  int   req_rises = 0;
  logic req_prev = 1'b0;

  always #5 clk = ~clk;

  memory_bridge dut (
    .clk(clk), .reset(reset),
    .memory_enable(memory_enable), .memory_command(memory_command),
    .address(address), .write_data(write_data), .byte_enable(byte_enable),
    .memory_ready(memory_ready), .memory_valid(memory_valid),
    .read_data(read_data), .bus_error(bus_error),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  memory_bridge #(.TIMEOUT_CYCLES(4), .TIMEOUT_WIDTH(8)) dut_to (
    .clk(clk), .reset(reset),
    .memory_enable(to_enable), .memory_command(memory_command),
    .address(address), .write_data(write_data), .byte_enable(byte_enable),
    .memory_ready(to_ready), .memory_valid(to_valid),
    .read_data(to_rdata), .bus_error(to_err),
    .bus_req(to_bus_req), .bus_we(to_bus_we), .bus_addr(to_bus_addr),
    .bus_wdata(to_bus_wdata), .bus_be(to_bus_be),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  // Count completion pulses and bus transactions of the main instance.
  always @(posedge clk) begin
    req_prev <= bus_req;
    if (memory_valid) valid_cnt <= valid_cnt + 1;
    if (bus_req && !req_prev) req_rises <= req_rises + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic sb_pop(input string tag);
    exp_t e;
    n_cmp++;
    assert (sb_q.size() != 0) else begin
      n_err++;
      $error("FAIL %s: observed=unexpected valid expected=empty scoreboard", tag);
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk({tag, "_rdata"}, read_data, e.rdata);
      chk({tag, "_err"}, {31'd0, bus_error}, {31'd0, e.err});
    end
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (!memory_valid && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_seen"}, {31'd0, memory_valid}, 32'd1);
    if (memory_valid) sb_pop(tag);
  endtask

  initial begin
    int base_rises;
    int base_valid;
    int cnt;

    // Reset state
    step();
    chk("rst_ready_low", {31'd0, memory_ready}, 32'd0);
    step();
    reset = 1'b0;
    #1;
    chk("rst_ready", {31'd0, memory_ready}, 32'd1);
    chk("rst_req", {31'd0, bus_req}, 32'd0);
    chk("rst_valid", {31'd0, memory_valid}, 32'd0);
    chk("rst_rdata", read_data, 32'h0);
    chk("rst_be", {28'd0, bus_be}, 32'h0);
    chk("rst_addr", bus_addr, 32'h0);

    // 1: read, ack in first REQUEST cycle
    memory_enable = 1'b1; memory_command = 1'b0; address = 32'h100;
    byte_enable = 4'b0001;
    step();
    memory_enable = 1'b0;
    chk("t1_req", {31'd0, bus_req}, 32'd1);
    chk("t1_be", {28'd0, bus_be}, 32'hF);
    chk("t1_we", {31'd0, bus_we}, 32'd0);
    chk("t1_addr", bus_addr, 32'h100);
    chk("t1_ready", {31'd0, memory_ready}, 32'd0);
    bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
    sb_q.push_back('{rdata: 32'hDEADBEEF, err: 1'b0});
    step();
    bus_ack = 1'b0;
    chk("t1_valid_lat", {31'd0, memory_valid}, 32'd1);
    if (memory_valid) sb_pop("t1");
    chk("t1_req_drop", {31'd0, bus_req}, 32'd0);
    chk("t1_ready_resp", {31'd0, memory_ready}, 32'd0);
    step();
    chk("t1_valid_once", {31'd0, memory_valid}, 32'd0);
    chk("t1_ready_back", {31'd0, memory_ready}, 32'd1);

    // 2: write, ack in fifth REQUEST cycle
    memory_enable = 1'b1; memory_command = 1'b1; address = 32'h203;
    write_data = 32'h00AA0000; byte_enable = 4'b0100;
    sb_q.push_back('{rdata: 32'hDEADBEEF, err: 1'b0});
    step();
    memory_enable = 1'b0; write_data = 32'h0; address = 32'h0; byte_enable = 4'h0;
    for (int i = 0; i < 5; i++) begin
      chk("t2_req", {31'd0, bus_req}, 32'd1);
      chk("t2_we", {31'd0, bus_we}, 32'd1);
      chk("t2_addr", bus_addr, 32'h200);
      chk("t2_wdata", bus_wdata, 32'h00AA0000);
      chk("t2_be", {28'd0, bus_be}, 32'h4);
      chk("t2_novalid", {31'd0, memory_valid}, 32'd0);
      if (i == 4) begin
        bus_ack = 1'b1; bus_rdata = 32'h77777777;
      end
      step();
    end
    bus_ack = 1'b0;
    chk("t2_valid", {31'd0, memory_valid}, 32'd1);
    if (memory_valid) sb_pop("t2");
    step();
    chk("t2_valid_once", {31'd0, memory_valid}, 32'd0);

    // 3: timeout on the 4-cycle instance, after a good read to preload data
    to_enable = 1'b1; memory_command = 1'b0; address = 32'h40;
    step();
    to_enable = 1'b0;
    bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
    step();
    bus_ack = 1'b0;
    chk("t3_pre_valid", {31'd0, to_valid}, 32'd1);
    chk("t3_pre_rdata", to_rdata, 32'hCAFEF00D);
    step();
    to_enable = 1'b1;
    step();
    to_enable = 1'b0;
    cnt = 0;
    while (to_bus_req && cnt < 20) begin
      cnt++;
      step();
    end
    chk("t3_req_cycles", cnt, 32'd4);
    chk("t3_valid", {31'd0, to_valid}, 32'd1);
    chk("t3_err", {31'd0, to_err}, 32'd1);
    chk("t3_rdata", to_rdata, 32'h0);
    step();
    chk("t3_ready", {31'd0, to_ready}, 32'd1);
    chk("t3_valid_once", {31'd0, to_valid}, 32'd0);

    // 4: enable held high across three back-to-back reads
    base_rises = req_rises;
    memory_enable = 1'b1; memory_command = 1'b0; address = 32'h300;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_req", {31'd0, bus_req}, 32'd1);
      chk("t4_ready_req", {31'd0, memory_ready}, 32'd0);
      bus_ack = 1'b1; bus_rdata = 32'h1000 + i;
      sb_q.push_back('{rdata: 32'h1000 + i, err: 1'b0});
      step();
      bus_ack = 1'b0;
      chk("t4_ready_resp", {31'd0, memory_ready}, 32'd0);
      wait_valid("t4", 4);
      if (i == 2) memory_enable = 1'b0;
      step();
      chk("t4_idle_noreq", {31'd0, bus_req}, 32'd0);
      chk("t4_ready_idle", {31'd0, memory_ready}, 32'd1);
    end
    step();
    chk("t4_txn_count", req_rises - base_rises, 32'd3);

    // 5: reset in second REQUEST cycle, late ack afterwards
    memory_enable = 1'b1; memory_command = 1'b0; address = 32'h500;
    step();
    memory_enable = 1'b0;
    base_valid = valid_cnt;
    step();
    chk("t5_req2", {31'd0, bus_req}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h5555AAAA;
    #1;
    chk("t5_req_drop", {31'd0, bus_req}, 32'd0);
    chk("t5_ready", {31'd0, memory_ready}, 32'd1);
    step();
    bus_ack = 1'b0;
    chk("t5_novalid", {31'd0, memory_valid}, 32'd0);
    chk("t5_rdata", read_data, 32'h0);
    step();
    chk("t5_valid_count", valid_cnt - base_valid, 32'd0);

    // 6: spurious ack while idle
    memory_enable = 1'b1; memory_command = 1'b0; address = 32'h600;
    step();
    memory_enable = 1'b0;
    bus_ack = 1'b1; bus_rdata = 32'hA5A50001;
    sb_q.push_back('{rdata: 32'hA5A50001, err: 1'b0});
    step();
    bus_ack = 1'b0;
    wait_valid("t6_pre", 4);
    step();
    base_valid = valid_cnt;
    bus_ack = 1'b1; bus_rdata = 32'h00001234;
    step();
    step();
    bus_ack = 1'b0;
    chk("t6_novalid", {31'd0, memory_valid}, 32'd0);
    chk("t6_rdata_kept", read_data, 32'hA5A50001);
    chk("t6_ready", {31'd0, memory_ready}, 32'd1);
    step();
    chk("t6_valid_count", valid_cnt - base_valid, 32'd0);
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
